shared_reg_arbiter: RTL
=======================

Name: shared_reg_arbiter

Overview:
- Round-robin arbiter plus write sequencer for one shared WIDTH-bit register built from async-reset D flip-flops.
- NUM_REQ requesters compete to load the register.
- The winner owns the register for a burst of up to MAX_BURST consecutive writes, then must yield.
- Sits between multiple producers and a single shared state register.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
WIDTH, 8, width of shared register and each write-data lane
MAX_BURST, 4, maximum consecutive writes per grant (>=1)

Ports:
clk  input  1  rising-edge clock
rstn  input  1  asynchronous active-low reset
req  input  NUM_REQ  per-requester write request, level
wdata  input  NUM_REQ*WIDTH  flattened write data; lane i = wdata[i*WIDTH +: WIDTH]
gnt  output  NUM_REQ  registered one-hot grant; all-zero when idle
gnt_id  output  $clog2(NUM_REQ)  index of current owner, valid when wr_valid=1
wr_valid  output  1  high in the cycle after a write to q
q  output  WIDTH  shared register contents

Behaviour:
- One clock domain, clk. Reset is asynchronous and active-low on rstn: q=0, gnt=0, gnt_id=0, wr_valid=0, state=IDLE, rr_ptr=0, burst_cnt=0. Assertion takes effect immediately, mid-burst included. On release, the first edge evaluates from IDLE.
- All outputs are registered. Latency: req/wdata sampled at edge E; q, gnt, gnt_id and wr_valid reflect that write after E.
- Meaning of gnt[i]=1 in a cycle: lane i's data sampled at the previous edge is now in q.
- Round-robin select, pick(start): lowest index k>=start with req[k]=1, searching start..NUM_REQ-1, then 0..start-1. Pure function of the current req.
- State IDLE:
  - req==0: hold q; gnt=0, wr_valid=0.
  - else w=pick(rr_ptr): q<=lane w, gnt<=onehot(w), gnt_id<=w, burst_cnt<=1, wr_valid<=1, go BUSY.
- State BUSY (owner o = gnt_id):
  - Continue when req[o]=1 and burst_cnt<MAX_BURST: q<=lane o, burst_cnt++, gnt unchanged, wr_valid<=1.
  - Yield otherwise (owner dropped req, or burst_cnt==MAX_BURST):
    - rr_ptr<=(o+1) mod NUM_REQ.
    - If any req: w=pick((o+1) mod NUM_REQ), immediate handover with no idle cycle; q<=lane w, gnt<=onehot(w), gnt_id<=w, burst_cnt<=1, stay BUSY.
    - Else gnt<=0, wr_valid<=0, hold q, go IDLE.
  - Exhausted owner that is the only requester: regranted via pick (new burst, burst_cnt=1).
- rr_ptr updates only on yield; an IDLE grant does not update it.
- MAX_BURST=1: every edge with any req rotates.
- Width rules: burst_cnt is $clog2(MAX_BURST+1) bits and never exceeds MAX_BURST. rr_ptr wraps NUM_REQ-1 -> 0; non-power-of-2 NUM_REQ wraps explicitly.
- Invariants: gnt is one-hot or zero; wr_valid==|gnt; q changes only on edges that set wr_valid.
- wdata on non-granted lanes is ignored. X on unrequested lanes must not propagate to q.

Test Plan:
- Reset: drive req=4'b1111, assert rstn=0 mid-burst -> q=0, gnt=0, wr_valid=0 immediately; after release, first grant goes to index 0.
- Single requester: req=4'b0100 held 6 edges, lane2=8'hA5 -> gnt=4'b0100 on all 6 cycles. burst_cnt wraps 1..4 then regrants to 2; q=8'hA5 throughout, wr_valid=1 continuously.
- Burst limit and rotation: req=4'b1111 held, lanes 0..3 = 8'h10,8'h21,8'h32,8'h43 -> grants 0,0,0,0,1,1,1,1,2,...; q follows the owner lane; no gap cycles at handovers.
- Early drop: owner 1 drops req after 2 writes, req[3]=1 -> next edge gnt=4'b1000, gnt_id=3. Then all req=0 -> gnt=0, wr_valid=0, q holds last value.
- Wrap-around: owner 3 yields with req=4'b0011 -> next grant index 0, not 1. rr_ptr=0.
- Idle/no-write: req=0 for 10 cycles with wdata toggling -> q constant, wr_valid=0, gnt=0.

Source files
------------

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter and write sequencer for one shared WIDTH-bit register.
// The winning requester owns the register for up to MAX_BURST consecutive writes.
module shared_reg_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*WIDTH-1:0]   wdata,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [$clog2(NUM_REQ)-1:0] gnt_id,
    output logic                       wr_valid,
    output logic [WIDTH-1:0]           q
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int BC_W  = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t             state_q,     state_d;
    logic [IDX_W-1:0]   rr_ptr_q,    rr_ptr_d;
    logic [BC_W-1:0]    burst_cnt_q, burst_cnt_d;
    logic [NUM_REQ-1:0] gnt_q,       gnt_d;
    logic [IDX_W-1:0]   gnt_id_q,    gnt_id_d;
    logic               wr_valid_q,  wr_valid_d;
    logic [WIDTH-1:0]   data_q,      data_d;

    logic [WIDTH-1:0]   lanes [NUM_REQ];
    logic [IDX_W-1:0]   owner;
    logic [IDX_W-1:0]   next_ptr;
    logic [IDX_W-1:0]   pick_start;
    logic [IDX_W-1:0]   winner;

    // Only the selected lane reaches q, so X on unrequested lanes never leaks in.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_lanes
        assign lanes[g] = wdata[g*WIDTH +: WIDTH];
    end

    // First requester at or after start, wrapping explicitly for any NUM_REQ.
    function automatic logic [IDX_W-1:0] pick(input logic [NUM_REQ-1:0] r,
                                              input logic [IDX_W-1:0]   start);
        logic [IDX_W-1:0] res;
        logic [IDX_W-1:0] idx_v;
        logic             found;
        int               idx;
        res   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(start) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            idx_v = IDX_W'(idx);
            if (!found && r[idx_v]) begin
                res   = idx_v;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    assign owner      = gnt_id_q;
    assign next_ptr   = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + IDX_W'(1);
    assign pick_start = (state_q == IDLE) ? rr_ptr_q : next_ptr;
    assign winner     = pick(req, pick_start);

    always_comb begin
        // NOTE: every variable gets its hold value first so no path can infer a latch.
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        gnt_d       = gnt_q;
        gnt_id_d    = gnt_id_q;
        wr_valid_d  = wr_valid_q;
        data_d      = data_q;

        unique case (state_q)
            IDLE: begin
                gnt_d      = '0;
                wr_valid_d = 1'b0;
                if (|req) begin
                    data_d      = lanes[winner];
                    gnt_d       = NUM_REQ'(1'b1) << winner;
                    gnt_id_d    = winner;
                    burst_cnt_d = BC_W'(1);
                    wr_valid_d  = 1'b1;
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                if (req[owner] && (burst_cnt_q < BC_W'(MAX_BURST))) begin
                    data_d      = lanes[owner];
                    burst_cnt_d = burst_cnt_q + BC_W'(1);
                    wr_valid_d  = 1'b1;
                end else begin
                    rr_ptr_d = next_ptr;
                    if (|req) begin
                        // Handover happens on this same edge; no idle gap.
                        data_d      = lanes[winner];
                        gnt_d       = NUM_REQ'(1'b1) << winner;
                        gnt_id_d    = winner;
                        burst_cnt_d = BC_W'(1);
                        wr_valid_d  = 1'b1;
                    end else begin
                        gnt_d       = '0;
                        wr_valid_d  = 1'b0;
                        state_d     = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
            gnt_q       <= '0;
            gnt_id_q    <= '0;
            wr_valid_q  <= 1'b0;
            data_q      <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values together.
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            wr_valid_q  <= wr_valid_d;
            data_q      <= data_d;
        end
    end

    assign gnt      = gnt_q;
    assign gnt_id   = gnt_id_q;
    assign wr_valid = wr_valid_q;
    assign q        = data_q;

endmodule
